// File: rtl/halftone_stream_converter_pkg.sv
// Shared types and constants for the streaming error-diffusion halftoner.
package halftone_stream_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ht_state_t;

    // Threshold-dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, shifting left
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Error words carry two headroom bits over the pixel width (sign + overshoot)
    function automatic int unsigned calc_err_w(input int unsigned pix_w);
        return pix_w + 32'd2;
    endfunction

endpackage

// File: rtl/halftone_stream_converter_if.sv
// Grey-pixel input stream and halftone-bit output stream, both valid/ready.
interface halftone_stream_converter_if #(
    parameter int unsigned PIX_W = 8
) ();
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             ht_valid;
    logic             ht_ready;
    logic             ht_bit;
    logic             ht_eol;
    logic             ht_eof;

    modport master (
        output pix_valid, pix_data, ht_ready,
        input  pix_ready, ht_valid, ht_bit, ht_eol, ht_eof
    );

    modport slave (
        input  pix_valid, pix_data, ht_ready,
        output pix_ready, ht_valid, ht_bit, ht_eol, ht_eof
    );
endinterface

// File: rtl/halftone_stream_converter_ht_err_line_buf.sv
// One row of signed diffusion errors; reads at col and col+1, writes at col
// (reads see the pre-write contents in the same cycle).
module halftone_stream_converter_ht_err_line_buf #(
    parameter int unsigned COLS  = 8,
    parameter int unsigned ERR_W = 10,
    parameter int unsigned CW    = 3
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [CW-1:0]           i_col,
    input  logic signed [ERR_W-1:0] i_wdata,
    output logic signed [ERR_W-1:0] o_rd_u,
    output logic signed [ERR_W-1:0] o_rd_ur
);

    logic signed [ERR_W-1:0] r_mem [COLS];
    logic [CW-1:0]           w_col_nxt;

    // Right-neighbour address wraps at the last column; the caller masks that read
    assign w_col_nxt = (i_col == CW'(COLS - 1)) ? '0 : i_col + CW'(1);
    assign o_rd_u    = r_mem[i_col];
    assign o_rd_ur   = r_mem[w_col_nxt];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_col] <= i_wdata;
        end
    end

endmodule

// File: rtl/halftone_stream_converter.sv
// Streaming error-diffusion halftoner: grey pixels in raster order, one bit per pixel out.
// Optional macro HT_THRESH_DITHER_EN adds LFSR jitter to the quantiser threshold.
module halftone_stream_converter
    import halftone_stream_converter_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned ROWS      = 6,
    parameter int unsigned THRESHOLD = 128,
    parameter int unsigned W_L       = 2,
    parameter int unsigned W_UL      = 8,
    parameter int unsigned W_U       = 4,
    parameter int unsigned W_UR      = 2,
    parameter int unsigned SHIFT     = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    halftone_stream_converter_if.slave  s_if,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int unsigned ERR_W = calc_err_w(PIX_W);
    localparam int unsigned MAXV  = (2 ** PIX_W) - 1;
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SUM_W = ERR_W + SHIFT + 2;

    localparam logic signed [SUM_W-1:0]   C_W_L    = SUM_W'(W_L);
    localparam logic signed [SUM_W-1:0]   C_W_UL   = SUM_W'(W_UL);
    localparam logic signed [SUM_W-1:0]   C_W_U    = SUM_W'(W_U);
    localparam logic signed [SUM_W-1:0]   C_W_UR   = SUM_W'(W_UR);
    localparam logic signed [ERR_W:0]     C_THR    = (ERR_W + 1)'(THRESHOLD);
    localparam logic signed [ERR_W+1:0]   C_MAX    = (ERR_W + 2)'(MAXV);
    localparam logic signed [ERR_W+1:0]   C_ZERO   = '0;
    localparam logic signed [ERR_W+1:0]   C_ERR_HI = (ERR_W + 2)'((2 ** (ERR_W - 1)) - 1);
    localparam logic signed [ERR_W+1:0]   C_ERR_LO = (ERR_W + 2)'(-(2 ** (ERR_W - 1)));

    ht_state_t               r_state;
    ht_state_t               w_state_next;
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic signed [ERR_W-1:0] r_err_l;
    logic signed [ERR_W-1:0] r_err_ul;
    logic                    r_ht_valid;
    logic                    r_ht_bit;
    logic                    r_ht_eol;
    logic                    r_ht_eof;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_pix_ready;
    logic                    w_accept;
    logic                    w_start_frame;
    logic                    w_col_first;
    logic                    w_col_last;
    logic                    w_row_first;
    logic                    w_last_pix;
    logic signed [ERR_W-1:0] w_rd_u;
    logic signed [ERR_W-1:0] w_rd_ur;
    logic signed [ERR_W-1:0] w_e_l;
    logic signed [ERR_W-1:0] w_e_ul;
    logic signed [ERR_W-1:0] w_e_u;
    logic signed [ERR_W-1:0] w_e_ur;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [ERR_W-1:0] w_e_av;
    logic signed [ERR_W:0]   w_cpv;
    logic signed [ERR_W:0]   w_thr;
    logic                    w_out;
    logic signed [ERR_W+1:0] w_diff;
    logic signed [ERR_W-1:0] w_err;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, input handshake and frame-start strobe
    always_comb begin
        w_state_next  = r_state;
        w_pix_ready   = 1'b0;
        w_accept      = 1'b0;
        w_start_frame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_start_frame = 1'b1;
                    w_state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                w_pix_ready = !r_ht_valid || s_if.ht_ready;
                w_accept    = w_pix_ready && s_if.pix_valid;
                if (w_accept && w_last_pix) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_ht_valid && s_if.ht_ready) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_col_first = (r_col == '0);
    assign w_col_last  = (r_col == CW'(COLS - 1));
    assign w_row_first = (r_row == '0);
    assign w_last_pix  = w_col_last && (r_row == RW'(ROWS - 1));

    halftone_stream_converter_ht_err_line_buf #(
        .COLS  (COLS),
        .ERR_W (ERR_W),
        .CW    (CW)
    ) u_line_buf (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_col   (r_col),
        .i_wdata (w_err),
        .o_rd_u  (w_rd_u),
        .o_rd_ur (w_rd_ur)
    );

    // Frame borders read as zero error; row 0 ignores whatever the buffer holds
    assign w_e_l  = w_col_first ? '0 : r_err_l;
    assign w_e_ul = (w_row_first || w_col_first) ? '0 : r_err_ul;
    assign w_e_u  = w_row_first ? '0 : w_rd_u;
    assign w_e_ur = (w_row_first || w_col_last) ? '0 : w_rd_ur;

    assign w_sum  = C_W_L  * SUM_W'(w_e_l)  + C_W_UL * SUM_W'(w_e_ul)
                  + C_W_U  * SUM_W'(w_e_u)  + C_W_UR * SUM_W'(w_e_ur);
    assign w_e_av = ERR_W'(w_sum >>> SHIFT);
    assign w_cpv  = $signed((ERR_W + 1)'(s_if.pix_data)) + (ERR_W + 1)'(w_e_av);
    assign w_out  = (w_cpv >= w_thr);
    assign w_diff = (ERR_W + 2)'(w_cpv) - (w_out ? C_MAX : C_ZERO);
    assign w_err  = (w_diff > C_ERR_HI) ? ERR_W'(C_ERR_HI) :
                    (w_diff < C_ERR_LO) ? ERR_W'(C_ERR_LO) : ERR_W'(w_diff);

`ifdef HT_THRESH_DITHER_EN
    logic [15:0] r_lfsr;

    // Reseeded per frame so every frame sees the same jitter sequence
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_start_frame) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_thr = C_THR + (ERR_W + 1)'($signed(r_lfsr[3:0])) - (ERR_W + 1)'(8);
`else
    assign w_thr = C_THR;
`endif

    // Raster counters, diffusion registers and the single output slot
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_err_l    <= '0;
            r_err_ul   <= '0;
            r_ht_valid <= 1'b0;
            r_ht_bit   <= 1'b0;
            r_ht_eol   <= 1'b0;
            r_ht_eof   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
            r_done <= (w_state_next == ST_DONE);
            if (w_start_frame) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                r_err_l  <= w_err;
                r_err_ul <= w_rd_u;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_last_pix ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (w_accept) begin
                r_ht_valid <= 1'b1;
                r_ht_bit   <= w_out;
                r_ht_eol   <= w_col_last;
                r_ht_eof   <= w_last_pix;
            end else if (s_if.ht_ready) begin
                r_ht_valid <= 1'b0;
            end
        end
    end

    assign s_if.pix_ready = w_pix_ready;
    assign s_if.ht_valid  = r_ht_valid;
    assign s_if.ht_bit    = r_ht_bit;
    assign s_if.ht_eol    = r_ht_eol;
    assign s_if.ht_eof    = r_ht_eof;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_halftone_stream_converter.sv
// Self-checking bench for halftone_stream_converter against an integer error-diffusion model.
module tb_halftone_stream_converter;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NPIX = COLS * ROWS;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    halftone_stream_converter_if #(.PIX_W(8)) bus ();

    halftone_stream_converter #(
        .PIX_W(8), .COLS(COLS), .ROWS(ROWS), .THRESHOLD(128),
        .W_L(2), .W_UL(8), .W_U(4), .W_UR(2), .SHIFT(4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .s_if    (bus),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int img   [NPIX];
    int thr_m [NPIX];
    bit exp_bit [NPIX];
    bit got_bit [NPIX];
    bit got_eol [NPIX];
    bit got_eof [NPIX];
    bit t1_bit  [NPIX];
    int got_n;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Per-pixel quantiser threshold for one frame
    function automatic void set_thr();
`ifdef HT_THRESH_DITHER_EN
        int l;
        int nib;
        int fb;
        l = 'hACE1;
        for (int i = 0; i < NPIX; i++) begin
            nib = l % 16;
            if (nib >= 8) nib = nib - 16;
            thr_m[i] = 128 + nib - 8;
            fb = ((l / 32768) + (l / 8192) + (l / 4096) + (l / 1024)) % 2;
            l  = ((l * 2) + fb) % 65536;
        end
`else
        for (int i = 0; i < NPIX; i++) thr_m[i] = 128;
`endif
    endfunction

    // Floyd-Steinberg-style reference over the whole frame
    function automatic void model_frame();
        int prev [COLS];
        int cur  [COLS];
        int el, eul, eu, eur, e, cpv, err, k;
        bit o;
        set_thr();
        for (int c = 0; c < COLS; c++) begin prev[c] = 0; cur[c] = 0; end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                k   = r * COLS + c;
                el  = (c > 0) ? cur[c-1] : 0;
                eul = (r > 0 && c > 0) ? prev[c-1] : 0;
                eu  = (r > 0) ? prev[c] : 0;
                eur = (r > 0 && c < COLS - 1) ? prev[c+1] : 0;
                e   = floor_div(2 * el + 8 * eul + 4 * eu + 2 * eur, 16);
                cpv = img[k] + e;
                o   = (cpv >= thr_m[k]);
                err = cpv - (o ? MAXV : 0);
                if (err > 511) err = 511;
                if (err < -512) err = -512;
                cur[c] = err;
                exp_bit[k] = o;
            end
            for (int c = 0; c < COLS; c++) prev[c] = cur[c];
        end
    endfunction

    // Drives one frame; -1 disables each optional disturbance
    task automatic run_frame(input int stall_at, input bit rand_bp, input int start_at,
                             input int reset_at, input string tag);
        int in_idx, cyc, stall_left, done_seen, done_at;
        bit stalled, start_pulsed, acc, hs;
        in_idx = 0; cyc = 0; stall_left = 0; done_seen = 0; done_at = -1;
        stalled = 0; start_pulsed = 0; got_n = 0;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.ht_ready  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %0b, required 1", tag, busy);
        end
        while (got_n < NPIX && cyc < 3000) begin
            start = (in_idx == start_at && !start_pulsed);
            if (start) start_pulsed = 1;
            if (in_idx == stall_at && !stalled) begin
                stalled = 1;
                stall_left = 5;
            end
            if (stall_left > 0) bus.ht_ready = 1'b0;
            else if (rand_bp)   bus.ht_ready = ($urandom_range(0, 3) != 0);
            else                bus.ht_ready = 1'b1;
            if (in_idx == reset_at) begin
                rst = 1'b1;
                start = 1'b0;
                bus.pix_valid = 1'b0;
                bus.ht_ready  = 1'b1;
                @(negedge clk);
                #1;
                n_checks++;
                if ({bus.ht_valid, busy, bus.pix_ready} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s after_reset: ht_valid=%0b busy=%0b pix_ready=%0b, required all 0",
                             tag, bus.ht_valid, busy, bus.pix_ready);
                end
                rst = 1'b0;
                return;
            end
            bus.pix_valid = (in_idx < NPIX);
            if (in_idx < NPIX) bus.pix_data = 8'(img[in_idx]);
            #1;
            if (stall_left > 0) begin
                n_checks++;
                if (bus.pix_ready !== 1'b0 || bus.ht_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: pix_ready=%0b ht_valid=%0b, required 0/1",
                             tag, bus.pix_ready, bus.ht_valid);
                end
                stall_left--;
            end
            acc = bus.pix_valid && bus.pix_ready;
            hs  = bus.ht_valid && bus.ht_ready;
            if (hs) begin
                got_bit[got_n] = bus.ht_bit;
                got_eol[got_n] = bus.ht_eol;
                got_eof[got_n] = bus.ht_eof;
                got_n++;
            end
            if (acc) in_idx++;
            if (done) done_seen++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.ht_ready  = 1'b1;
        n_checks++;
        if (got_n != NPIX) begin
            n_fail++;
            $display("FAIL %s output_count: got %0d bits, required %0d (timeout)", tag, got_n, NPIX);
        end
        for (int t = 0; t < 4; t++) begin
            #1;
            if (done) begin
                done_seen++;
                if (done_at < 0) done_at = t;
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_seen != 1 || done_at != 0) begin
            n_fail++;
            $display("FAIL %s done_pulse: seen %0d cycles at %0d, required 1 cycle at 0", tag, done_seen, done_at);
        end
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after_done: got %0b, required 0", tag, busy);
        end
    endtask

    task automatic check_frame(input string tag);
        bit eol_e, eof_e;
        model_frame();
        for (int i = 0; i < got_n; i++) begin
            eol_e = ((i % COLS) == COLS - 1);
            eof_e = (i == NPIX - 1);
            n_checks++;
            if (got_bit[i] !== exp_bit[i] || got_eol[i] !== eol_e || got_eof[i] !== eof_e) begin
                n_fail++;
                $display("FAIL %s pixel %0d: bit=%0b eol=%0b eof=%0b, required bit=%0b eol=%0b eof=%0b",
                         tag, i, got_bit[i], got_eol[i], got_eof[i], exp_bit[i], eol_e, eof_e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.ht_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.pix_ready, bus.ht_valid, bus.ht_bit, bus.ht_eol, bus.ht_eof, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%0b v=%0b bit=%0b eol=%0b eof=%0b busy=%0b done=%0b, required all 0",
                     bus.pix_ready, bus.ht_valid, bus.ht_bit, bus.ht_eol, bus.ht_eof, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_uniform_128();
        for (int i = 0; i < NPIX; i++) img[i] = 128;
        run_frame(-1, 0, -1, -1, "uniform128");
        check_frame("uniform128");
        n_checks++;
        if (got_bit[0] !== 1'b1 || got_bit[1] !== 1'b0 || got_bit[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL uniform128_row0_start: got %0b%0b%0b, required 101", got_bit[0], got_bit[1], got_bit[2]);
        end
        for (int i = 0; i < NPIX; i++) t1_bit[i] = got_bit[i];
    endtask

    task automatic test_flat();
        for (int i = 0; i < NPIX; i++) img[i] = 0;
        run_frame(-1, 0, -1, -1, "flat0");
        check_frame("flat0");
        for (int i = 0; i < NPIX; i++) img[i] = MAXV;
        run_frame(-1, 0, -1, -1, "flat255");
        check_frame("flat255");
    endtask

    task automatic test_ramp_stall();
        int base;
        base = int'($urandom_range(0, 255));
        for (int i = 0; i < NPIX; i++) img[i] = (base + i * 11) % 256;
        run_frame(13, 0, -1, -1, "ramp_stall");
        check_frame("ramp_stall");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(-1, 0, -1, 20, "mid_reset");
        repeat (2) @(negedge clk);
        for (int i = 0; i < NPIX; i++) img[i] = 128;
        run_frame(-1, 0, -1, -1, "after_reset");
        check_frame("after_reset");
        n_checks++;
        if (got_bit != t1_bit) begin
            n_fail++;
            $display("FAIL after_reset_vs_cold: bitstream differs from the cold-start uniform frame (%0d bits), required identical", got_n);
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'($urandom_range(0, 255));
        for (int t = 0; t < 4; t++) begin
            #1;
            n_checks++;
            if (bus.pix_ready !== 1'b0 || bus.ht_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_accept: pix_ready=%0b ht_valid=%0b, required 0/0", bus.pix_ready, bus.ht_valid);
            end
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(-1, 0, 10, -1, "start_in_run");
        check_frame("start_in_run");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
            run_frame(-1, 1, -1, -1, "random_bp");
            check_frame("random_bp");
        end
    endtask

`ifdef HT_THRESH_DITHER_EN
    task automatic test_dither();
        for (int i = 0; i < NPIX; i++) img[i] = 128;
        run_frame(-1, 0, -1, -1, "dither128");
        check_frame("dither128");
    endtask
`endif

    initial begin
        test_reset();
        test_uniform_128();
        test_flat();
        test_ramp_stall();
        test_mid_reset();
        test_start_ignored();
        test_back_to_back();
`ifdef HT_THRESH_DITHER_EN
        test_dither();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
